// File: rtl/wptr_full_level.sv
// wptr_full_level: async-FIFO write side - read-pointer sync, Gray write pointer, full/almost-full, fill level, sticky overflow
module wptr_full_level #(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                wincr,
   input  logic [ADDRSIZE:0]   rptr_async,
   input  logic [ADDRSIZE:0]   afull_thresh,
   input  logic                wovf_clr,
   output logic                wen,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                wafull,
   output logic [ADDRSIZE:0]   wcount,
   output logic                wovf
);
   logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q;
   logic [ADDRSIZE:0] rptr_s, rbin_s, wbin, wbinnext, wgraynext, wcount_val;
   assign rptr_s = sync_q[SYNC_STAGES-1];
   for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
      assign rbin_s[i] = ^rptr_s[ADDRSIZE:i];
   end
   assign wen        = wincr & ~wfull & wrst;
   assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
   assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
   assign wcount_val = wbinnext - rbin_s;
   assign waddr      = wbin[ADDRSIZE-1:0];
   always_ff @(posedge wclk or negedge wrst)
      if (!wrst) begin
         sync_q <= '0;
         wbin   <= '0;
         wptr   <= '0;
         wfull  <= 1'b0;
         wafull <= 1'b0;
         wcount <= '0;
         wovf   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_async};
         wbin   <= wbinnext;
         wptr   <= wgraynext;
         wfull  <= wgraynext == {~rptr_s[ADDRSIZE:ADDRSIZE-1], rptr_s[ADDRSIZE-2:0]};
         wafull <= wcount_val >= afull_thresh;
         wcount <= wcount_val;
         wovf   <= (wincr & wfull) | (wovf & ~wovf_clr);
      end
endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level: directed stimulus with an occupancy-count reference; a monitor pops expected outputs and compares
module tb_wptr_full_level;
   localparam int A = 4;
   localparam int S = 2;
   localparam int D = 1 << A;
   localparam int M = 1 << (A + 1);

   logic         wclk = 1'b0;
   logic         wrst = 1'b0;
   logic         wincr = 1'b0;
   logic [A:0]   rptr_async = '0;
   logic [A:0]   afull_thresh = '0;
   logic         wovf_clr = 1'b0;
   logic         wen;
   logic [A-1:0] waddr;
   logic [A:0]   wptr;
   logic         wfull;
   logic         wafull;
   logic [A:0]   wcount;
   logic         wovf;

   wptr_full_level #(.ADDRSIZE(A), .SYNC_STAGES(S)) dut (
      .wclk(wclk), .wrst(wrst), .wincr(wincr), .rptr_async(rptr_async),
      .afull_thresh(afull_thresh), .wovf_clr(wovf_clr), .wen(wen), .waddr(waddr),
      .wptr(wptr), .wfull(wfull), .wafull(wafull), .wcount(wcount), .wovf(wovf)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      string tag;
      int    wen, waddr, wptr, wfull, wafull, wcount, wovf;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // reference: accepted-write count vs. read count seen after the sync delay
   int m_wr;
   int m_p[S];
   bit m_full, m_ovf;
   int thr = 12;

   function automatic int gray(input int b);
      return (b ^ (b >> 1)) % M;
   endfunction

   function automatic void model_reset();
      m_wr = 0;
      m_full = 0;
      m_ovf = 0;
      for (int i = 0; i < S; i++) m_p[i] = 0;
   endfunction

   task automatic step(input bit wi, input int rd, input bit clr, input string tag);
      exp_t e;
      bit   wen_c;
      int   cnt;
      @(negedge wclk);
      wincr        = wi;
      rptr_async   = (A+1)'(gray(rd % M));
      wovf_clr     = clr;
      afull_thresh = (A+1)'(thr);
      wen_c = wi && !m_full;
      m_ovf = (wi && m_full) || (m_ovf && !clr);
      m_wr  = (m_wr + int'(wen_c)) % M;
      cnt   = (m_wr - m_p[S-1] + M) % M;
      m_full = (cnt == D);
      for (int i = S - 1; i > 0; i--) m_p[i] = m_p[i-1];
      m_p[0] = rd % M;
      e.tag = tag;
      e.wen = int'(wi && !m_full);
      e.waddr = m_wr % D;
      e.wptr = gray(m_wr);
      e.wfull = int'(m_full);
      e.wafull = int'(cnt >= thr);
      e.wcount = cnt;
      e.wovf = int'(m_ovf);
      sb.push_back(e);
   endtask

   function automatic void push_zero(input string tag);
      exp_t e;
      e.tag = tag;
      e.wen = 0; e.waddr = 0; e.wptr = 0; e.wfull = 0;
      e.wafull = 0; e.wcount = 0; e.wovf = 0;
      sb.push_back(e);
   endfunction

   // reset lands just after an edge; outputs must be zero before the next edge
   task automatic async_reset(input string tag);
      @(negedge wclk);
      wincr = 1'b1;
      wovf_clr = 1'b0;
      rptr_async = (A+1)'($urandom_range(0, M - 1));
      @(posedge wclk);
      #1 wrst = 1'b0;
      push_zero(tag);
      model_reset();
      repeat (2) @(negedge wclk);
      wincr = 1'b0;
      rptr_async = '0;
      wrst = 1'b1;
   endtask

   function automatic void chk(input string tag, input string f, input int act, input int ex);
      if (act != ex) begin
         n_bad++;
         $display("FAIL %s.%s: got %0d, expected %0d", tag, f, act, ex);
      end
   endfunction

   initial forever begin
      exp_t e;
      @(posedge wclk);
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         chk(e.tag, "wen", int'(wen), e.wen);
         chk(e.tag, "waddr", int'(waddr), e.waddr);
         chk(e.tag, "wptr", int'(wptr), e.wptr);
         chk(e.tag, "wfull", int'(wfull), e.wfull);
         chk(e.tag, "wafull", int'(wafull), e.wafull);
         chk(e.tag, "wcount", int'(wcount), e.wcount);
         chk(e.tag, "wovf", int'(wovf), e.wovf);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rd, wt, lag;
      model_reset();
      @(posedge wclk);
      #1 push_zero("rst0");
      @(negedge wclk);
      wrst = 1'b1;
      thr = 12;
      step(1, 0, 0, "first");
      for (int i = 1; i < D; i++) step(1, 0, 0, "fill");
      repeat (3) step(1, 0, 0, "ovf");
      step(1, 0, 1, "ovf_setwins");
      step(0, 0, 1, "ovf_clr");
      step(0, 0, 0, "ovf_idle");
      repeat (3) step(0, 5, 0, "drain");
      step(0, 5, 0, "drain_hold");
      rd = 5;
      wt = D;
      for (int i = 0; i < 100; i++) begin
         lag = $urandom_range(3, 10);
         if (wt - lag > rd) rd = wt - lag;
         step(1, rd, 0, "wrap");
         wt++;
      end
      thr = 0;
      step(0, rd, 0, "thr0");
      thr = D + 1;
      step(0, rd, 0, "thr_over");
      thr = 12;
      async_reset("rst_mid");
      step(1, 0, 0, "post_rst");
      step(1, 0, 0, "post_rst2");
      repeat (3) @(posedge wclk);
      #3;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain_queue: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-domain pointer and status block for the dual-clock packet FIFOs in the UDP filter datapath. It generalises the basic write-pointer/full logic with an internal read-pointer synchroniser of configurable depth, a registered fill level, a programmable almost-full flag and a sticky overflow flag. It sits on the write (MAC receive) side of each asynchronous FIFO, driving the RAM write address and enable and exporting a Gray write pointer to the read domain.

## Interface
- ADDRSIZE, 4, RAM address width; depth = 2^ADDRSIZE; legal range ≥ 2
- SYNC_STAGES, 2, flop stages on the incoming read pointer; legal range ≥ 2
- wclk  in  1  write clock
- wrst  in  1  reset, asynchronous, active-low
- wincr  in  1  write request for the current cycle
- rptr_async  in  ADDRSIZE+1  Gray read pointer from the read domain, not synchronised
- afull_thresh  in  ADDRSIZE+1  almost-full threshold, quasi-static
- wovf_clr  in  1  clears the sticky overflow flag
- wen  out  1  RAM write enable: wincr & ~wfull, combinational
- waddr  out  ADDRSIZE  RAM write address: low bits of the binary write pointer
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain
- wfull  out  1  registered full flag
- wafull  out  1  registered almost-full flag
- wcount  out  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE
- wovf  out  1  sticky overflow flag

## Operation
- Synchroniser: rptr_async passes through a chain of SYNC_STAGES flops clocked by wclk; the chain output is rptr_s. rptr_s drives rbin_s through a combinational Gray-to-binary conversion, where rbin_s[i] is the XOR of rptr_s[ADDRSIZE:i].
- Binary write pointer: wbinnext = wbin + wen. The increment is ADDRSIZE+1 bits wide and wraps naturally from 2^(ADDRSIZE+1)-1 to 0.
- Gray write pointer: wgraynext = (wbinnext >> 1) ^ wbinnext.
- Full: wfull_val = (wgraynext == {~rptr_s[ADDRSIZE:ADDRSIZE-1], rptr_s[ADDRSIZE-2:0]}).
- Fill level: wcount_val = wbinnext - rbin_s, computed modulo 2^(ADDRSIZE+1). The result never exceeds 2^ADDRSIZE.
- Almost-full: wafull_val = (wcount_val >= afull_thresh). A threshold of 0 keeps wafull asserted. A threshold above 2^ADDRSIZE keeps wafull deasserted.
- Overflow: set when wincr & wfull. Cleared when wovf_clr is high. If set and clear happen in the same cycle, set wins.
- Writes while full are dropped: wen = 0, and the pointers, waddr and wcount hold.
- All registers clear asynchronously when wrst is low: wbin, wptr, waddr, wfull, wafull, wcount, wovf and every synchroniser stage go to 0. wen = 0 during reset because wincr is ignored.
- Reset in mid-operation discards FIFO contents on the write side. Reset of the read side is coordinated at system level; this block does not handle it.

## Timing
- All outputs except wen are registered on posedge wclk.
- A write accepted at edge k (wen = 1 in the preceding cycle) updates waddr, wptr and wcount at edge k. The next write uses the new waddr.
- wfull asserts at the same edge as the write that fills the FIFO. The cycle after the last accepted write therefore already shows wfull = 1 and wen = 0.
- wafull asserts at the same edge as the write that makes wcount_val ≥ afull_thresh.
- Read-side latency: a change on rptr_async first affects wfull, wafull and wcount after SYNC_STAGES+1 wclk edges. This makes wfull and wcount pessimistic: never under-reporting occupancy.
- Simultaneous write and read progress: wcount reflects both in the same update (wbinnext − rbin_s).
- wovf goes high one edge after the offending cycle and stays high until cleared. The clear takes effect at the next edge.

## Test plan
- Reset: assert wrst mid-stream with random rptr_async → all outputs 0 immediately (asynchronous); after release, the first write lands at waddr = 0 and wptr = 1.
- Fill (ADDRSIZE = 4, SYNC_STAGES = 2, rptr_async = 0, afull_thresh = 12): 16 back-to-back writes → wafull rises at the edge where wcount = 12; wfull rises at the edge where wcount = 16; waddr wraps to 0.
- Overflow: while full, pulse wincr for 3 cycles → wen = 0, wptr and wcount unchanged, wovf = 1. Pulse wovf_clr together with a further wincr → wovf stays 1. Pulse wovf_clr alone → wovf = 0 after 1 edge.
- Drain latency: from full, set rptr_async to Gray(5) → wfull stays 1 for exactly 2 edges, then drops on the 3rd edge with wcount = 11 and wafull = 0.
- Wrap-around: 100 writes with rptr_async following at a lag of 3–10 entries → wptr passes through 31→0 correctly; wcount always equals the true occupancy plus sync lag; wfull never asserts.
- Parameter sweep: ADDRSIZE ∈ {2, 6}, SYNC_STAGES ∈ {2, 3} → fill, drain-latency and overflow checks pass with depth and latency scaled accordingly.
